// File: rtl/instr_fetch_ctrl_if.sv
// Fetch sequencer bus bundle.
// Groups the ROM read port, the redirect/halt controls and the decode-side
// valid/ready output stream of instr_fetch_ctrl.
//   master : seen by instr_fetch_ctrl (drives ROM request and decode output)
//   slave  : seen by the ROM/decode/control environment
// Signals:
//   mem_re, mem_a, mem_rd         ROM read enable, word address, read data
//   redirect_valid, redirect_pc   single-cycle redirect and byte target
//   halt                          level, stop issuing new fetches
//   out_valid, out_ready          decode handshake
//   out_instr, out_pc             fetched word and its byte PC
//   fetch_err                     misaligned-redirect flag
interface instr_fetch_ctrl_if #(
  parameter int unsigned N = 1024
);
  localparam int unsigned AW = $clog2(N);

  logic          mem_re;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_rd;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          halt;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic          fetch_err;

  modport master (
    output mem_re, mem_a, out_valid, out_instr, out_pc, fetch_err,
    input  mem_rd, redirect_valid, redirect_pc, halt, out_ready
  );

  modport slave (
    input  mem_re, mem_a, out_valid, out_instr, out_pc, fetch_err,
    output mem_rd, redirect_valid, redirect_pc, halt, out_ready
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer in front of a synchronous 1-cycle instruction ROM.
// Owns the fetch PC, issues ROM reads with credit-based flow control, buffers
// returned words in a 2-entry FIFO and presents {instr, pc} to decode.
// Ports:
//   clk  clock, all state on posedge
//   rst  synchronous active-high reset
//   bus  instr_fetch_ctrl_if.master (ROM port, redirect/halt, decode stream)
// Build option: define FETCH_MISALIGN_CHK_EN to flag misaligned redirect
// targets (sticky fetch_err plus halt); otherwise redirect targets are
// forced word-aligned and fetch_err is tied low.
module instr_fetch_ctrl #(
  parameter int unsigned N        = 1024,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_ctrl_if.master bus
);
  localparam int unsigned AW = $clog2(N);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] fpc_q;
  logic [31:0] rsp_pc_q;
  logic        rsp_v_q;
  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_pc_q    [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q;

  logic        deq;
  logic        issue;
  logic [2:0]  credit;
  logic        misalign;
  logic        err_flag;
  logic [31:0] redir_target;

`ifdef FETCH_MISALIGN_CHK_EN
  logic err_q;

  assign misalign     = bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
  assign redir_target = bus.redirect_pc;
  assign err_flag     = err_q;

  // Sticky until reset or the next redirect, which re-evaluates alignment.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      err_q <= misalign;
    end
  end
`else
  assign misalign     = 1'b0;
  assign redir_target = {bus.redirect_pc[31:2], 2'b00};
  assign err_flag     = 1'b0;
`endif

  // Redirect blanks the output so a dequeue in that cycle has no effect.
  assign bus.out_valid = !rst & !bus.redirect_valid & (count_q != 2'd0);
  assign deq           = bus.out_valid & bus.out_ready;

  // Words already owed to the FIFO after this cycle's dequeue; keep <= 2.
  assign credit = {1'b0, count_q} + {2'b00, rsp_v_q} - {2'b00, deq};
  assign issue  = !rst & (state_q == S_RUN) & !bus.redirect_valid & !bus.halt
                & (credit < 3'd2);

  assign bus.mem_re    = issue;
  assign bus.mem_a     = fpc_q[AW+1:2];
  assign bus.out_instr = rst ? 32'h0 : fifo_instr_q[rd_ptr_q];
  assign bus.out_pc    = rst ? 32'h0 : fifo_pc_q[rd_ptr_q];
  assign bus.fetch_err = !rst & err_flag;

  // The redirect cycle itself is the one-cycle bubble: nothing issues while
  // redirect_valid is high, and the target issues on the following cycle.
  always_comb begin
    state_d = state_q;
    if (bus.redirect_valid) begin
      state_d = (bus.halt | misalign) ? S_HALT : S_RUN;
    end else if (bus.halt) begin
      state_d = S_HALT;
    end else if ((state_q == S_HALT) && !err_flag) begin
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RUN;
      fpc_q    <= RESET_PC;
      rsp_pc_q <= 32'h0;
      rsp_v_q  <= 1'b0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_instr_q[i] <= 32'h0;
        fifo_pc_q[i]    <= 32'h0;
      end
    end else begin
      state_q <= state_d;
      if (bus.redirect_valid) begin
        // Flush buffered words and squash the read in flight.
        fpc_q    <= redir_target;
        rsp_v_q  <= 1'b0;
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
        count_q  <= 2'd0;
      end else begin
        if (rsp_v_q) begin
          fifo_instr_q[wr_ptr_q] <= bus.mem_rd;
          fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
          wr_ptr_q               <= ~wr_ptr_q;
        end
        if (deq) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
        count_q <= count_q + {1'b0, rsp_v_q} - {1'b0, deq};
        if (issue) begin
          rsp_pc_q <= fpc_q;
          fpc_q    <= fpc_q + 32'd4;
        end
        rsp_v_q <= issue;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  instr_fetch_ctrl_if #(.N(1024)) bus ();

  instr_fetch_ctrl #(.N(1024), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // ROM model: ROM[k] = k + 0x100, registered read, holds while re=0.
  always_ff @(posedge clk) begin
    if (bus.mem_re) bus.mem_rd <= 32'h100 + {22'b0, bus.mem_a};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.halt = 1'b0;
    bus.out_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.halt = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      vectors++;
      if (bus.mem_re !== 1'b0) begin
        miscompares++; $display("FAIL reset_mem_re: got %0h want 0", bus.mem_re);
      end
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++; $display("FAIL reset_out_valid: got %0h want 0", bus.out_valid);
      end
      vectors++;
      if (bus.out_instr !== 32'h0 || bus.out_pc !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_out_data: got %h/%h want 0/0", bus.out_instr, bus.out_pc);
      end
      vectors++;
      if (bus.fetch_err !== 1'b0) begin
        miscompares++; $display("FAIL reset_fetch_err: got %0h want 0", bus.fetch_err);
      end
      step();
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.mem_re !== 1'b1 || bus.mem_a !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_release_issue: got re=%0h a=%0h want re=1 a=0", bus.mem_re, bus.mem_a);
    end
  endtask

  task automatic test_stream();
    restart();
    for (int c = 0; c < 8; c++) begin
      #1;
      vectors++;
      if (bus.mem_re !== 1'b1 || bus.mem_a !== 10'(c)) begin
        miscompares++;
        $display("FAIL stream_issue c%0d: got re=%0h a=%0h want re=1 a=%0h",
                 c, bus.mem_re, bus.mem_a, c);
      end
      vectors++;
      if (bus.out_valid !== (c >= 2)) begin
        miscompares++;
        $display("FAIL stream_valid c%0d: got %0h want %0h", c, bus.out_valid, c >= 2);
      end
      if (c >= 2) begin
        vectors++;
        if (bus.out_pc !== 32'((c - 2) * 4) || bus.out_instr !== 32'(32'h100 + c - 2)) begin
          miscompares++;
          $display("FAIL stream_data c%0d: got pc=%h instr=%h want pc=%h instr=%h",
                   c, bus.out_pc, bus.out_instr, (c - 2) * 4, 32'h100 + c - 2);
        end
      end
      step();
    end
  endtask

  task automatic test_stall();
    restart();
    repeat (8) step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (bus.mem_re !== 1'b0) begin
        miscompares++; $display("FAIL stall_mem_re i%0d: got %0h want 0", i, bus.mem_re);
      end
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'd24 || bus.out_instr !== 32'h106) begin
        miscompares++;
        $display("FAIL stall_hold i%0d: got v=%0h pc=%h instr=%h want v=1 pc=18 instr=106",
                 i, bus.out_valid, bus.out_pc, bus.out_instr);
      end
      step();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(24 + 4 * i)
          || bus.out_instr !== 32'(32'h106 + i)) begin
        miscompares++;
        $display("FAIL stall_release i%0d: got v=%0h pc=%h instr=%h want v=1 pc=%h instr=%h",
                 i, bus.out_valid, bus.out_pc, bus.out_instr, 24 + 4 * i, 32'h106 + i);
      end
      vectors++;
      if (bus.mem_re !== 1'b1 || bus.mem_a !== 10'(8 + i)) begin
        miscompares++;
        $display("FAIL stall_reissue i%0d: got re=%0h a=%0h want re=1 a=%0h",
                 i, bus.mem_re, bus.mem_a, 8 + i);
      end
      step();
    end
  endtask

  task automatic test_redirect();
    restart();
    repeat (5) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.mem_re !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_cycle: got v=%0h re=%0h want 0/0", bus.out_valid, bus.mem_re);
    end
    step();
    bus.redirect_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      if (i <= 2) begin
        vectors++;
        if (bus.mem_re !== 1'b1 || bus.mem_a !== 10'(32'h10 + i - 1)) begin
          miscompares++;
          $display("FAIL redir_issue R+%0d: got re=%0h a=%0h want re=1 a=%0h",
                   i, bus.mem_re, bus.mem_a, 32'h10 + i - 1);
        end
        vectors++;
        if (bus.out_valid !== 1'b0) begin
          miscompares++; $display("FAIL redir_flush R+%0d: got v=%0h want 0", i, bus.out_valid);
        end
      end else begin
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(32'h40 + 4 * (i - 3))
            || bus.out_instr !== 32'(32'h110 + i - 3)) begin
          miscompares++;
          $display("FAIL redir_data R+%0d: got v=%0h pc=%h instr=%h want v=1 pc=%h instr=%h",
                   i, bus.out_valid, bus.out_pc, bus.out_instr,
                   32'h40 + 4 * (i - 3), 32'h110 + i - 3);
        end
      end
      step();
    end
  endtask

  task automatic test_halt();
    restart();
    repeat (5) step();
    bus.halt = 1'b1;
    for (int h = 0; h < 4; h++) begin
      #1;
      vectors++;
      if (bus.mem_re !== 1'b0) begin
        miscompares++; $display("FAIL halt_no_issue h%0d: got %0h want 0", h, bus.mem_re);
      end
      vectors++;
      if (h < 2) begin
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(12 + 4 * h)
            || bus.out_instr !== 32'(32'h103 + h)) begin
          miscompares++;
          $display("FAIL halt_drain h%0d: got v=%0h pc=%h instr=%h want v=1 pc=%h instr=%h",
                   h, bus.out_valid, bus.out_pc, bus.out_instr, 12 + 4 * h, 32'h103 + h);
        end
      end else if (bus.out_valid !== 1'b0) begin
        miscompares++; $display("FAIL halt_empty h%0d: got v=%0h want 0", h, bus.out_valid);
      end
      step();
    end
    bus.halt = 1'b0;
    #1;
    vectors++;
    if (bus.mem_re !== 1'b0) begin
      miscompares++; $display("FAIL halt_release_cycle: got re=%0h want 0", bus.mem_re);
    end
    step();
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (bus.mem_re !== 1'b1 || bus.mem_a !== 10'(5 + i)) begin
        miscompares++;
        $display("FAIL halt_resume i%0d: got re=%0h a=%0h want re=1 a=%0h",
                 i, bus.mem_re, bus.mem_a, 5 + i);
      end
      step();
    end
    #1;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'd20 || bus.out_instr !== 32'h105) begin
      miscompares++;
      $display("FAIL halt_resume_data: got v=%0h pc=%h instr=%h want v=1 pc=14 instr=105",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_reset_mid();
    restart();
    repeat (5) step();
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.mem_re !== 1'b0 || bus.out_instr !== 32'h0) begin
      miscompares++;
      $display("FAIL rstmid_during: got v=%0h re=%0h instr=%h want 0/0/0",
               bus.out_valid, bus.mem_re, bus.out_instr);
    end
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (bus.mem_re !== 1'b1 || bus.mem_a !== 10'(c)) begin
        miscompares++;
        $display("FAIL rstmid_issue c%0d: got re=%0h a=%0h want re=1 a=%0h",
                 c, bus.mem_re, bus.mem_a, c);
      end
      vectors++;
      if (c < 2 && bus.out_valid !== 1'b0) begin
        miscompares++; $display("FAIL rstmid_discard c%0d: got v=%0h want 0", c, bus.out_valid);
      end else if (c == 2 && (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0
                              || bus.out_instr !== 32'h100)) begin
        miscompares++;
        $display("FAIL rstmid_restart: got v=%0h pc=%h instr=%h want v=1 pc=0 instr=100",
                 bus.out_valid, bus.out_pc, bus.out_instr);
      end
      step();
    end
  endtask

  task automatic test_misalign();
    restart();
    repeat (5) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h42;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL misal_cycle: got v=%0h want 0", bus.out_valid);
    end
    step();
    bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (bus.fetch_err !== 1'b1 || bus.mem_re !== 1'b0 || bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL misal_err i%0d: got err=%0h re=%0h v=%0h want 1/0/0",
                 i, bus.fetch_err, bus.mem_re, bus.out_valid);
      end
      step();
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h80;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    vectors++;
    if (bus.fetch_err !== 1'b0 || bus.mem_re !== 1'b1 || bus.mem_a !== 10'h20) begin
      miscompares++;
      $display("FAIL misal_clear: got err=%0h re=%0h a=%0h want 0/1/20",
               bus.fetch_err, bus.mem_re, bus.mem_a);
    end
    step();
    step();
    #1;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h80 || bus.out_instr !== 32'h120) begin
      miscompares++;
      $display("FAIL misal_resume: got v=%0h pc=%h instr=%h want v=1 pc=80 instr=120",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
`else
    #1;
    vectors++;
    if (bus.fetch_err !== 1'b0 || bus.mem_re !== 1'b1 || bus.mem_a !== 10'h10) begin
      miscompares++;
      $display("FAIL align_force: got err=%0h re=%0h a=%0h want 0/1/10",
               bus.fetch_err, bus.mem_re, bus.mem_a);
    end
    step();
    step();
    #1;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40 || bus.out_instr !== 32'h110) begin
      miscompares++;
      $display("FAIL align_data: got v=%0h pc=%h instr=%h want v=1 pc=40 instr=110",
               bus.out_valid, bus.out_pc, bus.out_instr);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_reset_mid();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
